// File: rtl/timer_pkg.sv
// Shared types and limits for the hh:mm:ss timers (countdown and time-of-day).
package timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSED  = 2'd2,
      ST_EXPIRED = 2'd3
   } timer_state_e;

   localparam logic [5:0] MAX_SEC  = 6'd59;
   localparam logic [5:0] MAX_MIN  = 6'd59;
   localparam logic [5:0] MAX_HOUR = 6'd23;

   // True when every field of an hh:mm:ss preset is inside its 24-hour range.
   function automatic logic hms_legal(input logic [5:0] h,
                                      input logic [5:0] m,
                                      input logic [5:0] s);
      return (h <= MAX_HOUR) && (m <= MAX_MIN) && (s <= MAX_SEC);
   endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Prescaler: counts enabled clk cycles 0..TICKS_PER_SEC-1 and fires a
// one-cycle tick on the terminal count. clear has priority over enable.
module sec_tick_gen #(
   parameter int unsigned TICKS_PER_SEC = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   // With TICKS_PER_SEC=1 a one-bit counter that never leaves 0 makes every
   // enabled cycle a tick.
   localparam int unsigned   CW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CW-1:0] TERM = CW'(TICKS_PER_SEC - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick = enable && (cnt_q == TERM);

   // Next count: clear to 0, wrap on the tick, otherwise advance while enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = tick ? '0 : cnt_q + CW'(1);
      end
   end

   // Counter register, cleared asynchronously by the active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// Down-counting hh:mm:ss timer with load/start/pause strobes and expiry flag.
// Strobe priority each cycle is load > pause > start; any load strobe (even a
// rejected one) suppresses pause, start and the decrement in that cycle.
module countdown_timer
   import timer_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [5:0]   load_hours,
   input  logic [5:0]   load_min,
   input  logic [5:0]   load_sec,
   input  logic         start,
   input  logic         pause,
   output logic [5:0]   hours,
   output logic [5:0]   min,
   output logic [5:0]   sec,
   output logic         running,
   output logic         done,
   output logic         expired,
   output logic         load_err,
   output timer_state_e state_dbg
);

   timer_state_e state_q;
   timer_state_e state_d;
   logic [5:0]   hours_q;
   logic [5:0]   hours_d;
   logic [5:0]   min_q;
   logic [5:0]   min_d;
   logic [5:0]   sec_q;
   logic [5:0]   sec_d;
   logic         done_q;
   logic         done_d;
   logic         load_err_q;
   logic         load_err_d;

   logic load_ok;
   logic start_ok;
   logic value_zero;
   logic value_one;
   logic tick_en;
   logic tick_clr;
   logic tick;

   assign load_ok    = load && hms_legal(load_hours, load_min, load_sec);
   assign value_zero = (hours_q == 6'd0) && (min_q == 6'd0) && (sec_q == 6'd0);
   assign value_one  = (hours_q == 6'd0) && (min_q == 6'd0) && (sec_q == 6'd1);
   assign start_ok   = !load && !pause && start && !value_zero &&
                       ((state_q == ST_IDLE) || (state_q == ST_PAUSED));
   // Prescaler holds (not clears) across a pause; load and start restart it.
   assign tick_en    = !load && !pause && (state_q == ST_RUN);
   assign tick_clr   = load_ok || start_ok;

   sec_tick_gen #(
      .TICKS_PER_SEC (TICKS_PER_SEC)
   ) u_sec_tick_gen (
      .clk    (clk),
      .reset  (reset),
      .enable (tick_en),
      .clear  (tick_clr),
      .tick   (tick)
   );

   // Next state/value: load, then pause, then start, then tick-driven decrement.
   always_comb begin
      state_d    = state_q;
      hours_d    = hours_q;
      min_d      = min_q;
      sec_d      = sec_q;
      done_d     = 1'b0;
      load_err_d = 1'b0;
      if (load) begin
         if (load_ok) begin
            hours_d = load_hours;
            min_d   = load_min;
            sec_d   = load_sec;
            state_d = ST_IDLE;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (pause) begin
         if (state_q == ST_RUN) begin
            state_d = ST_PAUSED;
         end
      end else if (start_ok) begin
         state_d = ST_RUN;
      end else if ((state_q == ST_RUN) && tick) begin
         if (value_one) begin
            // Last second: land on 00:00:00 and expire on the same edge.
            sec_d   = 6'd0;
            state_d = ST_EXPIRED;
            done_d  = 1'b1;
         end else if (sec_q != 6'd0) begin
            sec_d = sec_q - 6'd1;
         end else begin
            sec_d = MAX_SEC;
            if (min_q != 6'd0) begin
               min_d = min_q - 6'd1;
            end else begin
               // Value is non-zero and not 00:00:01, so hours > 0 here.
               min_d   = MAX_MIN;
               hours_d = hours_q - 6'd1;
            end
         end
      end
   end

   // State, value and pulse registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         hours_q    <= 6'd0;
         min_q      <= 6'd0;
         sec_q      <= 6'd0;
         done_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         hours_q    <= hours_d;
         min_q      <= min_d;
         sec_q      <= sec_d;
         done_q     <= done_d;
         load_err_q <= load_err_d;
      end
   end

   assign hours     = hours_q;
   assign min       = min_q;
   assign sec       = sec_q;
   assign running   = (state_q == ST_RUN);
   assign expired   = (state_q == ST_EXPIRED);
   assign done      = done_q;
   assign load_err  = load_err_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: a TICKS_PER_SEC=4 instance for most
// scenarios and a TICKS_PER_SEC=1 instance for the full borrow chain.
module tb_countdown_timer;
   import timer_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       load;
   logic [5:0] ld_h;
   logic [5:0] ld_m;
   logic [5:0] ld_s;
   logic       start;
   logic       pause;

   logic [5:0]   h4, m4, s4, h1, m1, s1;
   logic         run4, done4, exp4, err4;
   logic         run1, done1, exp1, err1;
   timer_state_e st4, st1;

   int n_checks = 0;
   int n_fail   = 0;
   int early_done;

   countdown_timer #(.TICKS_PER_SEC(4)) u_dut4 (
      .clk        (clk),
      .reset      (rst_n),
      .load       (load),
      .load_hours (ld_h),
      .load_min   (ld_m),
      .load_sec   (ld_s),
      .start      (start),
      .pause      (pause),
      .hours      (h4),
      .min        (m4),
      .sec        (s4),
      .running    (run4),
      .done       (done4),
      .expired    (exp4),
      .load_err   (err4),
      .state_dbg  (st4)
   );

   countdown_timer #(.TICKS_PER_SEC(1)) u_dut1 (
      .clk        (clk),
      .reset      (rst_n),
      .load       (load),
      .load_hours (ld_h),
      .load_min   (ld_m),
      .load_sec   (ld_s),
      .start      (start),
      .pause      (pause),
      .hours      (h1),
      .min        (m1),
      .sec        (s1),
      .running    (run1),
      .done       (done1),
      .expired    (exp1),
      .load_err   (err1),
      .state_dbg  (st1)
   );

   // ---------------- helpers ----------------
   function automatic logic [31:0] hms(input logic [5:0] h, input logic [5:0] m,
                                       input logic [5:0] s);
      return {14'd0, h, m, s};
   endfunction

   function automatic logic [31:0] val4();
      return {14'd0, h4, m4, s4};
   endfunction

   function automatic logic [31:0] val1();
      return {14'd0, h1, m1, s1};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic step_n(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_load(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
      ld_h = h;
      ld_m = m;
      ld_s = s;
      load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst_n = 1'b0;
      load  = 1'b0;
      start = 1'b0;
      pause = 1'b0;
      ld_h  = '0;
      ld_m  = '0;
      ld_s  = '0;
      step_n(2);
      chk("reset_val", val4(), hms(0, 0, 0));
      chk("reset_flags", {28'd0, run4, done4, exp4, err4}, 32'd0);
      chk("reset_state", st4, ST_IDLE);
      chk("reset_val_t1", val1(), hms(0, 0, 0));
      rst_n = 1'b1;
      step();

      // Prescaler: 00:00:03 decrements at edges 4, 8, 12 after start.
      do_load(6'd0, 6'd0, 6'd3);
      chk("pre_load_val", val4(), hms(0, 0, 3));
      chk("pre_load_state", st4, ST_IDLE);
      pulse_start();
      chk("pre_running", run4, 1);
      step_n(3);
      chk("pre_c3", val4(), hms(0, 0, 3));
      step();
      chk("pre_c4", val4(), hms(0, 0, 2));
      step_n(4);
      chk("pre_c8", val4(), hms(0, 0, 1));
      step_n(3);
      chk("pre_c11_val", val4(), hms(0, 0, 1));
      chk("pre_c11_done", done4, 0);
      step();
      chk("pre_c12_val", val4(), hms(0, 0, 0));
      chk("pre_c12_done", done4, 1);
      chk("pre_c12_expired", exp4, 1);
      chk("pre_c12_running", run4, 0);
      chk("pre_c12_state", st4, ST_EXPIRED);
      step();
      chk("pre_c13_done", done4, 0);
      step_n(12);
      chk("pre_c25_val", val4(), hms(0, 0, 0));
      chk("pre_c25_expired", exp4, 1);
      chk("pre_c25_done", done4, 0);

      // Load while EXPIRED clears expired.
      do_load(6'd0, 6'd2, 6'd0);
      chk("exp_load_expired", exp4, 0);
      chk("exp_load_state", st4, ST_IDLE);
      chk("exp_load_val", val4(), hms(0, 2, 0));

      // Pause/resume: 00:01:00, pause on edge 6 -> 00:00:59 held.
      do_load(6'd0, 6'd1, 6'd0);
      pulse_start();
      step_n(5);
      chk("pr_c5_val", val4(), hms(0, 0, 59));
      pause = 1'b1;
      step();
      pause = 1'b0;
      chk("pr_paused_state", st4, ST_PAUSED);
      chk("pr_paused_running", run4, 0);
      chk("pr_paused_val", val4(), hms(0, 0, 59));
      step_n(20);
      chk("pr_hold_val", val4(), hms(0, 0, 59));
      chk("pr_hold_running", run4, 0);
      pulse_start();
      chk("pr_resume_running", run4, 1);
      step_n(3);
      chk("pr_resume_c3", val4(), hms(0, 0, 59));
      step();
      chk("pr_resume_c4", val4(), hms(0, 0, 58));

      // Pause on the tick edge suppresses the decrement.
      step_n(3);
      pause = 1'b1;
      step();
      pause = 1'b0;
      chk("pause_tick_val", val4(), hms(0, 0, 58));
      chk("pause_tick_state", st4, ST_PAUSED);

      // Load coincident with a tick while counting 00:00:02.
      do_load(6'd0, 6'd0, 6'd3);
      pulse_start();
      step_n(4);
      chk("col_c4", val4(), hms(0, 0, 2));
      step_n(3);
      chk("col_c7", val4(), hms(0, 0, 2));
      ld_h = 6'd0;
      ld_m = 6'd0;
      ld_s = 6'd5;
      load = 1'b1;
      step();
      load = 1'b0;
      chk("col_val", val4(), hms(0, 0, 5));
      chk("col_state", st4, ST_IDLE);
      chk("col_done", done4, 0);
      step();
      chk("col_hold", val4(), hms(0, 0, 5));

      // Illegal loads: each pulses load_err once, value/state unchanged.
      do_load(6'd24, 6'd0, 6'd0);
      chk("ill_h_err", err4, 1);
      chk("ill_h_val", val4(), hms(0, 0, 5));
      step();
      chk("ill_h_err_end", err4, 0);
      do_load(6'd0, 6'd60, 6'd0);
      chk("ill_m_err", err4, 1);
      chk("ill_m_val", val4(), hms(0, 0, 5));
      step();
      chk("ill_m_err_end", err4, 0);
      do_load(6'd0, 6'd0, 6'd60);
      chk("ill_s_err", err4, 1);
      chk("ill_s_val", val4(), hms(0, 0, 5));
      chk("ill_s_state", st4, ST_IDLE);
      step();
      chk("ill_s_err_end", err4, 0);

      // Upper-boundary legal load is accepted.
      do_load(6'd23, 6'd59, 6'd59);
      chk("max_load_val", val4(), hms(23, 59, 59));
      chk("max_load_err", err4, 0);

      // Start with 00:00:00 is ignored.
      do_load(6'd0, 6'd0, 6'd0);
      pulse_start();
      chk("zero_start_running", run4, 0);
      chk("zero_start_state", st4, ST_IDLE);

      // Borrow chain on the 1-tick instance: 01:00:00 runs down to zero.
      do_load(6'd1, 6'd0, 6'd0);
      pulse_start();
      chk("bc_start_val", val1(), hms(1, 0, 0));
      chk("bc_start_running", run1, 1);
      step();
      chk("bc_c1", val1(), hms(0, 59, 59));
      early_done = 0;
      for (int k = 2; k < 3600; k++) begin
         step();
         if (done1) early_done++;
         if (k == 61) chk("bc_c61", val1(), hms(0, 58, 59));
      end
      chk("bc_no_early_done", early_done, 0);
      chk("bc_c3599", val1(), hms(0, 0, 1));
      step();
      chk("bc_c3600_val", val1(), hms(0, 0, 0));
      chk("bc_c3600_done", done1, 1);
      chk("bc_c3600_expired", exp1, 1);
      step();
      chk("bc_c3601_done", done1, 0);
      chk("bc_c3601_val", val1(), hms(0, 0, 0));

      // Asynchronous reset in the middle of RUN.
      do_load(6'd0, 6'd0, 6'd5);
      pulse_start();
      step_n(2);
      chk("ar_running", run4, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_val", val4(), hms(0, 0, 0));
      chk("ar_flags", {28'd0, run4, done4, exp4, err4}, 32'd0);
      chk("ar_state", st4, ST_IDLE);
      step();
      rst_n = 1'b1;
      step();
      chk("ar_post_state", st4, ST_IDLE);
      chk("ar_post_running", run4, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Down-counting hh:mm:ss timer; the counterpart to the team's up-counting time-of-day counter.
- Loads a 24-hour-format duration, decrements once per second while running, and flags expiry.
- Sits beside the time-of-day counter and feeds the same hh:mm:ss display/alarm path.
- An internal prescaler derives the one-second tick from clk.

Parameters:
- TICKS_PER_SEC, 1, clk cycles per one-second decrement (>=1); 1 means every clk edge is one second.

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-low reset
- load  input  1  one-cycle strobe: capture load_hours/load_min/load_sec
- load_hours  input  6  preset hours, legal 0..23
- load_min  input  6  preset minutes, legal 0..59
- load_sec  input  6  preset seconds, legal 0..59
- start  input  1  one-cycle strobe: begin or resume counting
- pause  input  1  one-cycle strobe: halt counting, hold value
- hours  output  6  current remaining hours
- min  output  6  current remaining minutes
- sec  output  6  current remaining seconds
- running  output  1  high while in RUN
- done  output  1  one-cycle pulse when count reaches 00:00:00
- expired  output  1  sticky high in EXPIRED until next accepted load
- load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low. While reset=0, all outputs are 0, state=IDLE and the prescaler is 0, independent of clk.
- Outputs are registered. running and expired decode from the state register; done and load_err are registered pulses.
- States: IDLE, RUN, PAUSED, EXPIRED.
- Input priority each cycle: load > pause > start.
- load, accepted only if load_hours<=23, load_min<=59 and load_sec<=59:
  - The next edge copies the values to hours/min/sec, sets state=IDLE and clears the prescaler and expired.
  - Accepted from any state, including RUN mid-count.
- load with any field out of range: the value and state are unchanged; load_err=1 for one cycle.
- start:
  - From IDLE or PAUSED, with a non-zero value: go to RUN and clear the prescaler.
  - With a value of 00:00:00, or when already in RUN/EXPIRED: ignored.
- pause in RUN: go to PAUSED; value and prescaler are held. pause in any other state is ignored.
- Tick: while in RUN the prescaler counts 0..TICKS_PER_SEC-1 and the tick fires on the terminal count. The first decrement therefore lands TICKS_PER_SEC cycles after the start edge.
- Decrement on tick, borrow chain:
  - sec>0: sec-1.
  - sec=0: sec=59 and borrow from min.
  - min=0 on borrow: min=59 and borrow from hours.
  - hours never underflows, because 00:00:00 is intercepted first.
- Expiry: when a tick takes the value from 00:00:01 to 00:00:00:
  - On that same edge: state=EXPIRED, done=1 for exactly one cycle, expired=1.
  - The value stays 00:00:00 with no further decrements.
- Simultaneous events:
  - load wins over a same-cycle tick: the loaded value is taken and no decrement occurs.
  - pause on the tick cycle: the decrement does not occur.
- Width rules: all arithmetic is 6-bit. Use explicit comparisons against 0, 59 and 23; no modulo wrap.

Decomposition:
- Shared package timer_pkg holds:
  - State typedef (IDLE/RUN/PAUSED/EXPIRED).
  - Constants MAX_SEC=59, MAX_MIN=59, MAX_HOUR=23, shared with the time-of-day counter.
- One sub-module: sec_tick_gen, the prescaler. Inputs are clk, reset, enable and clear; output is a one-cycle tick.

Test Plan (TICKS_PER_SEC=4 unless noted):
- Reset mid-RUN: assert reset=0 asynchronously -> hours/min/sec/running/done/expired/load_err all 0 immediately; after reset=1, state is IDLE.
- Borrow chain, TICKS_PER_SEC=1: load 01:00:00, start -> next value 00:59:59; 3599 cycles later done pulses once with value 00:00:00 and expired=1.
- Prescaler: load 00:00:03, start -> sec decrements at cycles 4, 8 and 12 after start; done is high only in the cycle-12 window; 13 edges later the value is still 00:00:00.
- Pause/resume: load 00:01:00, start, pause after 6 cycles -> value 00:00:59 held for 20 cycles with running=0; start -> next decrement 4 cycles later to 00:00:58.
- Illegal loads: load 24:00:00, then 00:60:00, then 00:00:60 -> load_err pulses 3 times and the value is unchanged. Separately, start with 00:00:00 -> stays IDLE, running=0.
- Collisions: load 00:00:05 coincident with a tick while counting 00:00:02 -> value 00:00:05, state IDLE, no done. Load while EXPIRED -> expired clears.
